// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection controller.
// Holds the controller state enumeration, the default phase durations and
// the lamp bundle together with the state-to-lamp decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALL_RED_1,
    EW_GREEN,
    EW_YELLOW,
    ALL_RED_2,
    PED_WALK,
    NIGHT
  } state_t;

  localparam int DEF_COUNT_WIDTH = 16;
  localparam int DEF_T_GREEN     = 48;
  localparam int DEF_T_YELLOW    = 12;
  localparam int DEF_T_ALLRED    = 4;
  localparam int DEF_T_WALK      = 24;
  localparam int DEF_T_BLINK     = 8;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic walk;
  } lamps_t;

  // Lamp pattern shown while in state s; blink_on selects the lit half of
  // the night-flash period.
  function automatic lamps_t lamps_for(state_t s, logic blink_on);
    lamps_t l;
    l = '0;
    case (s)
      NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red   = 1'b1; end
      NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red   = 1'b1; end
      EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red   = 1'b1; end
      EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red   = 1'b1; end
      PED_WALK:  begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
      NIGHT:     begin l.ns_yellow = blink_on; l.ew_yellow = blink_on; end
      default:   begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter for the intersection controller.
// Counts up every cycle, returns to zero on i_clr (state change) or after
// reaching the terminal value i_term, which lets the same block serve as a
// one-shot phase timer and as the free-running night-flash counter.
// Ports: i_clk, i_rst_n (async, active-low), i_clr, i_term;
//        o_count (current), o_count_nxt (value after this edge),
//        o_done (o_count == i_term).
module phase_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_nxt,
  output logic             o_done
);

  assign o_done      = (o_count == i_term);
  assign o_count_nxt = (i_clr || o_done) ? '0 : o_count + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_count <= '0;
    else          o_count <= o_count_nxt;
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach traffic intersection controller with pedestrian walk phase
// and night-flash mode.
// Ports: i_clk, i_rst_n (async, active-low), i_ped_req (pulse, latched),
//        i_night (level, sampled at all-red exits and while in NIGHT);
//        o_ns_red/yellow/green, o_ew_red/yellow/green, o_walk (registered).
// Lamps are decoded from the next state and next count and registered, so
// they change on the same edge as the state register.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int T_GREEN     = DEF_T_GREEN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK,
  parameter int T_BLINK     = DEF_T_BLINK
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ped_req,
  input  logic i_night,
  output logic o_ns_red,
  output logic o_ns_yellow,
  output logic o_ns_green,
  output logic o_ew_red,
  output logic o_ew_yellow,
  output logic o_ew_green,
  output logic o_walk
);

  localparam longint MAX_COUNT = (64'sd1 <<< COUNT_WIDTH) - 1;

  if (COUNT_WIDTH < 1 || COUNT_WIDTH > 62) begin : g_bad_width
    $error("traffic_intersection_ctrl: COUNT_WIDTH out of range");
  end
  if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1 || T_BLINK < 1) begin : g_bad_time
    $error("traffic_intersection_ctrl: every T_* must be at least 1");
  end
  if (longint'(2 * T_BLINK - 1) > MAX_COUNT || longint'(T_GREEN - 1) > MAX_COUNT ||
      longint'(T_YELLOW - 1) > MAX_COUNT || longint'(T_ALLRED - 1) > MAX_COUNT ||
      longint'(T_WALK - 1) > MAX_COUNT) begin : g_bad_fit
    $error("traffic_intersection_ctrl: a terminal count does not fit COUNT_WIDTH");
  end

  localparam logic [COUNT_WIDTH-1:0] TC_GREEN  = COUNT_WIDTH'(T_GREEN - 1);
  localparam logic [COUNT_WIDTH-1:0] TC_YELLOW = COUNT_WIDTH'(T_YELLOW - 1);
  localparam logic [COUNT_WIDTH-1:0] TC_ALLRED = COUNT_WIDTH'(T_ALLRED - 1);
  localparam logic [COUNT_WIDTH-1:0] TC_WALK   = COUNT_WIDTH'(T_WALK - 1);
  localparam logic [COUNT_WIDTH-1:0] TC_NIGHT  = COUNT_WIDTH'(2 * T_BLINK - 1);
  localparam logic [COUNT_WIDTH-1:0] BLINK_ON  = COUNT_WIDTH'(T_BLINK);

  state_t                 state, state_nxt;
  logic                   ped_pending, ped_pending_nxt;
  logic [COUNT_WIDTH-1:0] term, count, count_nxt;
  logic                   done;
  logic                   state_change;
  lamps_t                 lamps_q, lamps_nxt;

  assign state_change = (state_nxt != state);

  phase_timer #(
    .WIDTH (COUNT_WIDTH)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (state_change),
    .i_term      (term),
    .o_count     (count),
    .o_count_nxt (count_nxt),
    .o_done      (done)
  );

  always_comb begin
    term = TC_ALLRED;
    case (state)
      NS_GREEN, EW_GREEN:   term = TC_GREEN;
      NS_YELLOW, EW_YELLOW: term = TC_YELLOW;
      PED_WALK:             term = TC_WALK;
      NIGHT:                term = TC_NIGHT;
      default:              term = TC_ALLRED;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NS_GREEN:  if (done) state_nxt = NS_YELLOW;
      NS_YELLOW: if (done) state_nxt = ALL_RED_1;
      ALL_RED_1: if (done) state_nxt = i_night ? NIGHT : EW_GREEN;
      EW_GREEN:  if (done) state_nxt = EW_YELLOW;
      EW_YELLOW: if (done) state_nxt = ALL_RED_2;
      ALL_RED_2: if (done) state_nxt = i_night ? NIGHT :
                                       (ped_pending ? PED_WALK : NS_GREEN);
      PED_WALK:  if (done) state_nxt = NS_GREEN;
      NIGHT:     if (!i_night) state_nxt = ALL_RED_2;
      default:   state_nxt = ALL_RED_2;
    endcase
  end

  // Entering the walk or night phase consumes the request; a request seen
  // on that same edge is considered served.
  always_comb begin
    ped_pending_nxt = ped_pending;
    if (state_change && (state_nxt == PED_WALK || state_nxt == NIGHT))
      ped_pending_nxt = 1'b0;
    else if (i_ped_req && state != NIGHT)
      ped_pending_nxt = 1'b1;
  end

  always_comb begin
    lamps_nxt = lamps_for(state_nxt, count_nxt < BLINK_ON);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ALL_RED_2;
      ped_pending <= 1'b0;
      lamps_q     <= lamps_for(ALL_RED_2, 1'b0);
    end else begin
      state       <= state_nxt;
      ped_pending <= ped_pending_nxt;
      lamps_q     <= lamps_nxt;
    end
  end

  assign o_ns_red    = lamps_q.ns_red;
  assign o_ns_yellow = lamps_q.ns_yellow;
  assign o_ns_green  = lamps_q.ns_green;
  assign o_ew_red    = lamps_q.ew_red;
  assign o_ew_yellow = lamps_q.ew_yellow;
  assign o_ew_green  = lamps_q.ew_green;
  assign o_walk      = lamps_q.walk;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl with small timing
// parameters, random requests and a phase-level reference model.
module tb_traffic_intersection_ctrl;

  localparam int CW = 8;
  localparam int TG = 8;
  localparam int TY = 3;
  localparam int TA = 2;
  localparam int TW = 5;
  localparam int TB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ped_req = 1'b0;
  logic night = 1'b0;
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: phase name, cycles spent in phase, pending request.
  string m_ph   = "AR2";
  int    m_age  = 0;
  bit    m_pend = 1'b0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .COUNT_WIDTH (CW),
    .T_GREEN     (TG),
    .T_YELLOW    (TY),
    .T_ALLRED    (TA),
    .T_WALK      (TW),
    .T_BLINK     (TB)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ped_req   (ped_req),
    .i_night     (night),
    .o_ns_red    (ns_r),
    .o_ns_yellow (ns_y),
    .o_ns_green  (ns_g),
    .o_ew_red    (ew_r),
    .o_ew_yellow (ew_y),
    .o_ew_green  (ew_g),
    .o_walk      (walk)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic int dur(input string ph);
    if (ph == "NSG" || ph == "EWG") return TG;
    if (ph == "NSY" || ph == "EWY") return TY;
    if (ph == "WALK") return TW;
    return TA;
  endfunction

  function automatic logic [6:0] exp_lamps();
    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    if (m_ph == "NSG")   return 7'b0011000;
    if (m_ph == "NSY")   return 7'b0101000;
    if (m_ph == "EWG")   return 7'b1000010;
    if (m_ph == "EWY")   return 7'b1000100;
    if (m_ph == "WALK")  return 7'b1001001;
    if (m_ph == "NIGHT") return (m_age < TB) ? 7'b0100100 : 7'b0000000;
    return 7'b1001000;
  endfunction

  task automatic model_reset();
    m_ph = "AR2"; m_age = 0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    string nx;
    nx = m_ph;
    if (m_ph == "NIGHT") begin
      if (!night) nx = "AR2";
    end else if (m_age == dur(m_ph) - 1) begin
      if (m_ph == "NSG")       nx = "NSY";
      else if (m_ph == "NSY")  nx = "AR1";
      else if (m_ph == "AR1")  nx = night ? "NIGHT" : "EWG";
      else if (m_ph == "EWG")  nx = "EWY";
      else if (m_ph == "EWY")  nx = "AR2";
      else if (m_ph == "AR2")  nx = night ? "NIGHT" : (m_pend ? "WALK" : "NSG");
      else                     nx = "NSG";
    end
    if (nx != m_ph && (nx == "WALK" || nx == "NIGHT")) m_pend = 1'b0;
    else if (ped_req && m_ph != "NIGHT") m_pend = 1'b1;
    if (nx != m_ph) m_age = 0;
    else if (m_ph == "NIGHT") m_age = (m_age + 1) % (2 * TB);
    else m_age = m_age + 1;
    m_ph = nx;
  endtask

  task automatic run_cycle(input logic req, input logic nt, input logic rst);
    @(negedge clk);
    ped_req = req;
    night   = nt;
    rst_n   = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    check("lamps", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}, exp_lamps());
    if (m_ph != "NIGHT") begin
      check("mutex", ((ns_g | ns_y) & (ew_g | ew_y)), 0);
      check("ns_onehot", $countones({ns_r, ns_y, ns_g}), 1);
      check("ew_onehot", $countones({ew_r, ew_y, ew_g}), 1);
    end
    check("walk_green", walk & (ns_g | ew_g), 0);
  endtask

  initial begin
    int rise[$];
    bit g_prev;
    int guard;
    int walk_cnt;
    logic nt;

    // Reset state
    model_reset();
    #12;
    check("reset_lamps", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}, 7'b1001000);
    run_cycle(1'b0, 1'b0, 1'b0);

    // Free-running cycle: first green and period
    cyc = 0;
    g_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (ns_g && !g_prev) rise.push_back(cyc);
      g_prev = ns_g;
    end
    if (rise.size() >= 2) begin
      check("first_green", rise[0], 2);
      check("period", rise[1] - rise[0], 26);
    end else check("green_seen", rise.size(), 2);

    // Pedestrian pulse during EW green
    guard = 0;
    while (m_ph != "EWG" && guard < 100) begin run_cycle(1'b0, 1'b0, 1'b1); guard++; end
    check("reach_ewg", (m_ph == "EWG"), 1);
    run_cycle(1'b1, 1'b0, 1'b1);
    walk_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (walk) begin
        walk_cnt++;
        check("walk_reds", {ns_r, ew_r}, 2'b11);
      end
    end
    check("walk_len", walk_cnt, TW);

    // Night requested during NS green, held, then released
    guard = 0;
    while (m_ph != "NSG" && guard < 100) begin run_cycle(1'b0, 1'b0, 1'b1); guard++; end
    check("reach_nsg", (m_ph == "NSG"), 1);
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b0, 1'b1);

    // Night and ped request both pending at ALL_RED_2 exit
    guard = 0;
    while (m_ph != "EWG" && guard < 100) begin run_cycle(1'b0, 1'b0, 1'b1); guard++; end
    run_cycle(1'b1, 1'b1, 1'b1);
    walk_cnt = 0;
    for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (walk) walk_cnt++;
    end
    check("no_walk_after_night", walk_cnt, 0);

    // Reset during EW yellow with a pending request
    guard = 0;
    while (m_ph != "EWG" && guard < 100) begin run_cycle(1'b0, 1'b0, 1'b1); guard++; end
    run_cycle(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_ph != "EWY" && guard < 100) begin run_cycle(1'b0, 1'b0, 1'b1); guard++; end
    check("reach_ewy", (m_ph == "EWY"), 1);
    check("pend_before_reset", m_pend, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}, 7'b1001000);
    run_cycle(1'b0, 1'b0, 1'b0);
    walk_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(1'b0, 1'b0, 1'b1);
      if (walk) walk_cnt++;
    end
    check("no_walk_after_reset", walk_cnt, 0);

    // Random traffic
    nt = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) nt = ~nt;
      run_cycle(($urandom_range(0, 15) == 0), nt, ($urandom_range(0, 499) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
